// File: rtl/synth_cfg_pkg.sv
// Shared constants and types for the synth config path: word map, command layout, loader states.
package synth_cfg_pkg;

    localparam int unsigned CEIL_LOG2_CFG_WORDS = 3;
    localparam int unsigned CFG_WORDS           = 1 << CEIL_LOG2_CFG_WORDS;
    localparam int unsigned CMD_WRITE_BIT       = 7;
    localparam int unsigned SPI_BYTE_W          = 8;
    localparam int unsigned SPI_BIT_CNT_W       = 3;

    // Word map of the cfg array
    localparam int unsigned OSC_PERIOD_BASE     = 0;
    localparam int unsigned MOD_PERIOD_BASE     = 4;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_CMD  = 2'd1,
        LD_DATA = 2'd2,
        LD_DROP = 2'd3
    } loader_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one async pin, with rise/fall detect against one extra registered copy.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to low so a pin already low at release never looks like a fresh falling edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/cfg_spi_loader.sv
// SPI mode-0 write-only loader: command byte then a byte burst, emitted as byte-lane cfg writes.
module cfg_spi_loader
    import synth_cfg_pkg::*;
#(
    parameter int unsigned CFG_ADDR_BITS = CEIL_LOG2_CFG_WORDS,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sck_in,
    input  logic                     cs_n_in,
    input  logic                     mosi_in,
    output logic [CFG_ADDR_BITS-1:0] cfg_w_addr,
    output logic [15:0]              cfg_w_data,
    output logic [1:0]               cfg_we,
    output logic                     busy,
    output logic                     frame_err
);

    localparam int unsigned BYTE_ADDR_W = CFG_ADDR_BITS + 1;

    logic sck_rise, sck_fall_unused, sck_lvl_unused;
    logic cs_rise, cs_fall, cs_lvl_unused;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk      (clk),
        .reset    (reset),
        .async_in (sck_in),
        .level    (sck_lvl_unused),
        .rise     (sck_rise),
        .fall     (sck_fall_unused)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk      (clk),
        .reset    (reset),
        .async_in (cs_n_in),
        .level    (cs_lvl_unused),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk      (clk),
        .reset    (reset),
        .async_in (mosi_in),
        .level    (mosi_lvl),
        .rise     (mosi_rise_unused),
        .fall     (mosi_fall_unused)
    );

    loader_state_t            state, state_nxt;
    logic [SPI_BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [SPI_BYTE_W-1:0]    shift_q, shift_nxt, shift_in;
    logic [BYTE_ADDR_W-1:0]   byte_addr, byte_addr_nxt;
    logic [CFG_ADDR_BITS-1:0] w_addr_nxt;
    logic [15:0]              w_data_nxt;
    logic [1:0]               we_nxt;
    logic                     err_nxt;
    logic                     last_bit;

    assign shift_in = {shift_q[SPI_BYTE_W-2:0], mosi_lvl};
    assign last_bit = (bit_cnt == SPI_BIT_CNT_W'(SPI_BYTE_W - 1));

    // State and output registers; reset drops any write or error decided this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LD_IDLE;
            bit_cnt    <= '0;
            shift_q    <= '0;
            byte_addr  <= '0;
            cfg_w_addr <= '0;
            cfg_w_data <= '0;
            cfg_we     <= '0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift_q    <= shift_nxt;
            byte_addr  <= byte_addr_nxt;
            cfg_w_addr <= w_addr_nxt;
            cfg_w_data <= w_data_nxt;
            cfg_we     <= we_nxt;
            busy       <= (state_nxt != LD_IDLE);
            frame_err  <= err_nxt;
        end
    end

    // Next-state and write decode; a cs_n rise pre-empts any sck rise in the same cycle
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift_q;
        byte_addr_nxt = byte_addr;
        w_addr_nxt    = cfg_w_addr;
        w_data_nxt    = cfg_w_data;
        we_nxt        = 2'b00;
        err_nxt       = 1'b0;

        if (cs_rise) begin
            if ((state == LD_CMD || state == LD_DATA) && bit_cnt != '0) begin
                err_nxt = 1'b1;
            end
            state_nxt   = LD_IDLE;
            bit_cnt_nxt = '0;
        end else begin
            case (state)
                LD_IDLE: begin
                    if (cs_fall) begin
                        state_nxt   = LD_CMD;
                        bit_cnt_nxt = '0;
                    end
                end
                LD_CMD: begin
                    if (sck_rise) begin
                        shift_nxt   = shift_in;
                        bit_cnt_nxt = bit_cnt + SPI_BIT_CNT_W'(1);
                        if (last_bit) begin
                            if (shift_in[CMD_WRITE_BIT]) begin
                                byte_addr_nxt = shift_in[BYTE_ADDR_W-1:0];
                                state_nxt     = LD_DATA;
                            end else begin
                                state_nxt     = LD_DROP;
                            end
                        end
                    end
                end
                LD_DATA: begin
                    if (sck_rise) begin
                        shift_nxt   = shift_in;
                        bit_cnt_nxt = bit_cnt + SPI_BIT_CNT_W'(1);
                        if (last_bit) begin
                            we_nxt        = byte_addr[0] ? 2'b10 : 2'b01;
                            w_addr_nxt    = byte_addr[BYTE_ADDR_W-1:1];
                            w_data_nxt    = {shift_in, shift_in};
                            byte_addr_nxt = byte_addr + BYTE_ADDR_W'(1);
                        end
                    end
                end
                LD_DROP: begin
                end
                default: begin
                    state_nxt = LD_IDLE;
                end
            endcase
        end
    end

endmodule
